// File: rtl/rv_imem_pkg.sv
// Shared types and defaults for the instruction-memory loader controller.
// Holds the FSM state encoding and the load-length validity helper.
package rv_imem_pkg;

  localparam int          DEF_ADDR_W   = 6;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_HALT  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  // A load must cover at least one word and never run past the top of the RAM.
  function automatic logic len_ok(input logic [31:0] len, input int addr_w);
    return (len != 32'd0) && (len <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word.
// The first accepted byte ends up in bits 7:0.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte
);

  logic [1:0] idx;

  assign last_byte = byte_en && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else if (clear) begin
      idx        <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_byte;
      if (byte_en) begin
        // Shift right so earlier bytes migrate toward the low end.
        word <= {byte_in, word[31:8]};
        idx  <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader_ctrl.sv
// Loads a program into instruction RAM from a byte stream, holding the core
// in reset and feeding it NOPs until the image is complete.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_HALT  | idle after reset, core held in reset, waiting for load/start
// ST_LOAD  | accepting bytes of the current word
// ST_WRITE | one-cycle RAM write of the assembled word
// ST_DONE  | one-cycle done pulse before releasing the core
// ST_RUN   | core running from RAM; a new load may be requested
module imem_loader_ctrl
  import rv_imem_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_data,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] LEN_ONE = 1;

  state_e          state, state_nx;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] wcnt;
  logic            err_q;

  logic            idle;
  logic            load_ok;
  logic            load_start;
  logic            load_bad;
  logic            last_word;

  logic            byte_en;
  logic            last_byte;
  logic            word_valid;
  logic [31:0]     word;

  assign idle       = (state == ST_HALT) || (state == ST_RUN);
  assign load_ok    = len_ok(32'(load_len), ADDR_W);
  assign load_start = idle && load_req && load_ok;
  assign load_bad   = idle && load_req && !load_ok;
  assign last_word  = (wcnt == (len_q - LEN_ONE));

  assign byte_ready = (state == ST_LOAD);
  assign byte_en    = byte_valid && byte_ready;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load_start),
    .byte_en    (byte_en),
    .byte_in    (byte_data),
    .word       (word),
    .word_valid (word_valid),
    .last_byte  (last_byte)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_HALT: begin
        // A load request, even a rejected one, masks start in the same cycle.
        if (load_start)
          state_nx = ST_LOAD;
        else if (!load_req && start)
          state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (load_start)
          state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (last_byte)
          state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        state_nx = last_word ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        state_nx = ST_RUN;
      end
      default: begin
        state_nx = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HALT;
      len_q <= '0;
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= load_bad;
      if (load_start) begin
        len_q <= load_len;
        wcnt  <= '0;
      end else if (state == ST_WRITE) begin
        wcnt  <= wcnt + LEN_ONE;
      end
    end
  end

  assign mem_raddr  = fetch_addr[ADDR_W+1:2];
  assign fetch_data = (state == ST_RUN) ? mem_rdata : NOP_WORD;
  assign cpu_rst_n  = (state == ST_RUN);

  assign mem_we     = (state == ST_WRITE);
  assign mem_waddr  = wcnt[ADDR_W-1:0];
  assign mem_wdata  = word;

  assign busy       = (state == ST_LOAD) || (state == ST_WRITE);
  assign done       = (state == ST_DONE);
  assign err        = err_q;

  logic unused_bits;
  assign unused_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0], word_valid};

endmodule

// File: doc/imem_loader_ctrl.md
IMEM_LOADER_CTRL -- requirements
Module: imem_loader_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 6, instruction RAM word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter: NOP_WORD, 32'h00000013, instruction returned to the core while not running.
REQ-003 SHALL have ports (one clock; reset asynchronous, active-low):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_req  in  1  start a program load (sampled each cycle)
- load_len  in  ADDR_W+1  words to load, sampled with load_req
- start  in  1  release core without loading
- byte_valid  in  1  loader byte stream valid
- byte_data  in  8  loader byte
- byte_ready  out  1  byte accepted when valid&ready
- fetch_addr  in  32  core PC (byte address)
- fetch_data  out  32  instruction to core
- mem_raddr  out  ADDR_W  RAM read index
- mem_rdata  in  32  RAM combinational read data
- mem_we  out  1  RAM write strobe
- mem_waddr  out  ADDR_W  RAM write index
- mem_wdata  out  32  RAM write data
- cpu_rst_n  out  1  active-low reset to core
- busy  out  1  high in LOAD/WRITE
- done  out  1  one-cycle pulse, load complete
- err  out  1  one-cycle pulse, bad load_len

Function
REQ-004 SHALL implement states HALT, LOAD, WRITE, DONE, RUN.
REQ-005 SHALL drive mem_raddr = fetch_addr[ADDR_W+1:2] in every state.
REQ-006 SHALL drive fetch_data = mem_rdata in RUN, NOP_WORD otherwise.
REQ-007 SHALL drive cpu_rst_n = 1 only in RUN.
REQ-008 HALT: load_req with valid len -> LOAD; else start -> RUN; load_req has priority over start.
REQ-009 Valid len = 1..2^ADDR_W; otherwise SHALL pulse err one cycle after sampling and stay in the current state.
REQ-010 RUN: load_req with valid len -> LOAD (cpu_rst_n low from next cycle); start ignored.
REQ-011 LOAD: byte_ready = 1; bytes packed little-endian (first byte -> bits 7:0); 4th accepted byte -> WRITE.
REQ-012 WRITE (exactly one cycle): mem_we = 1, mem_waddr = word counter, mem_wdata = packed word; byte_ready = 0.
REQ-013 Word counter SHALL start at 0 per load and increment after each write; after write of word load_len-1 -> DONE, else -> LOAD.
REQ-014 DONE (one cycle): done = 1, then -> RUN.
REQ-015 byte_ready SHALL be 0 outside LOAD; bytes offered then are not consumed.
REQ-016 load_req and start SHALL be ignored in LOAD, WRITE, DONE.
REQ-017 mem_we SHALL be 0 outside WRITE; loaded region never wraps (len <= depth).
REQ-018 Load of len N with no stalls SHALL take 5N+1 cycles from LOAD entry to RUN entry.

Reset
REQ-019 On rst_n low: state HALT, counters and packer cleared, cpu_rst_n=0, byte_ready=0, mem_we=0, busy=0, done=0, err=0, fetch_data=NOP_WORD.
REQ-020 Reset mid-load SHALL discard partial word; words already written remain in RAM.

Structure
REQ-021 Shared package rv_imem_pkg SHALL hold the state enum, NOP_WORD default and ADDR_W default.
REQ-022 Byte-to-word assembly SHALL be a sub-module byte_packer (2-bit byte index, 32-bit shift register, word_valid).

Verification
REQ-023 Reset, then start -> cpu_rst_n=1 next cycle; fetch_addr=8 gives mem_raddr=2, fetch_data=mem_rdata.
REQ-024 load_req, len=2, bytes 93,00,00,00,13,01,10,00 continuous -> writes [0]=00000093, [1]=00100113; done pulse; RUN after 11 cycles.
REQ-025 load_len=0 and load_len=65 (ADDR_W=6) -> err pulse each, state unchanged, no mem_we.
REQ-026 load_req in RUN -> cpu_rst_n low next cycle, fetch_data=00000013 throughout load.
REQ-027 Assert rst_n low after 2 bytes of word 1 -> HALT; new len=1 load writes [0] from fresh 4 bytes.
REQ-028 byte_valid toggling randomly, len=64 -> all 64 words correct, mem_we never high with byte_ready.
